// File: rtl/sync_mod_counter_if.sv
// Control and status bundle for one sync_mod_counter stage.
// The counter is the slave; whoever drives en/load/up/d is the master.
interface sync_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic             up;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, load, up, d,
        input  q, tc, wrap
    );

    modport slave (
        input  en, load, up, d,
        output q, tc, wrap
    );
endinterface

// File: rtl/sync_mod_counter.sv
// Synchronous modulo-N up/down counter with load, optional saturation,
// combinational terminal count for cascading and a registered wrap pulse.
module sync_mod_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input logic              clk,
    input logic              rst,
    sync_mod_counter_if.slave bus
);
    localparam longint unsigned SPAN = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
            longint'(MODULUS) > longint'(SPAN)) begin : g_bad_param
            $error("sync_mod_counter: illegal WIDTH/MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             at_top;
    logic             at_bot;

    assign at_top = (q_r == MAX);
    assign at_bot = (q_r == '0);

    // Explicit end-of-range compares even when MODULUS is a power of two.
    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            q_nxt = (bus.d > MAX) ? MAX : bus.d;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!at_top) begin
                    q_nxt = q_r + 1'b1;
                end else if (SATURATE == 0) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    q_nxt = q_r - 1'b1;
                end else if (SATURATE == 0) begin
                    q_nxt    = MAX;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.tc   = bus.en & ~bus.load & (bus.up ? at_top : at_bot);
endmodule

// File: tb/tb_sync_mod_counter.sv
// Bench for sync_mod_counter: vector tables per configuration plus a
// two-stage cascade, with a queue holding the expected post-edge state.
module tb_sync_mod_counter;
    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic       up;
        logic [2:0] d;
        logic       chk_tc;
        logic       tc;
        logic [2:0] q;
        logic       wrap;
    } vec_t;

    typedef struct {
        int         id;
        logic [5:0] q;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rst;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    sync_mod_counter_if #(.WIDTH(3)) if_a ();
    sync_mod_counter_if #(.WIDTH(3)) if_b ();
    sync_mod_counter_if #(.WIDTH(3)) if_c ();
    sync_mod_counter_if #(.WIDTH(3)) if_l ();
    sync_mod_counter_if #(.WIDTH(3)) if_h ();

    sync_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst[0]), .bus(if_a.slave));
    sync_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_b (
        .clk(clk), .rst(rst[1]), .bus(if_b.slave));
    sync_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst[2]), .bus(if_c.slave));
    sync_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_l (
        .clk(clk), .rst(rst[3]), .bus(if_l.slave));
    sync_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_h (
        .clk(clk), .rst(rst[3]), .bus(if_h.slave));

    assign if_h.en = if_l.tc;

    function automatic vec_t mk(logic r, logic e, logic l, logic u,
                                logic [2:0] d, logic ct, logic t,
                                logic [2:0] q, logic w);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.up = u; v.d = d;
        v.chk_tc = ct; v.tc = t; v.q = q; v.wrap = w;
        return v;
    endfunction

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(int id, vec_t v);
        case (id)
            0: begin
                rst[0] = v.rst; if_a.en = v.en; if_a.load = v.load;
                if_a.up = v.up; if_a.d = v.d;
            end
            1: begin
                rst[1] = v.rst; if_b.en = v.en; if_b.load = v.load;
                if_b.up = v.up; if_b.d = v.d;
            end
            default: begin
                rst[2] = v.rst; if_c.en = v.en; if_c.load = v.load;
                if_c.up = v.up; if_c.d = v.d;
            end
        endcase
    endtask

    function automatic logic [5:0] get_q(int id);
        case (id)
            0: return {3'd0, if_a.q};
            1: return {3'd0, if_b.q};
            2: return {3'd0, if_c.q};
            default: return {if_h.q, if_l.q};
        endcase
    endfunction

    function automatic logic get_tc(int id);
        case (id)
            0: return if_a.tc;
            1: return if_b.tc;
            default: return if_c.tc;
        endcase
    endfunction

    function automatic logic get_wrap(int id);
        case (id)
            0: return if_a.wrap;
            1: return if_b.wrap;
            2: return if_c.wrap;
            default: return if_l.wrap;
        endcase
    endfunction

    // Called at posedge+1; checks tc before the edge, q/wrap after it.
    task automatic run(int id, vec_t v, string tag);
        exp_t e;
        drive(id, v);
        #1;
        if (v.chk_tc) check({tag, ".tc"}, int'(get_tc(id)), int'(v.tc));
        e.id = id; e.q = {3'd0, v.q}; e.wrap = v.wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".q"}, int'(get_q(e.id)), int'(e.q));
        check({tag, ".wrap"}, int'(get_wrap(e.id)), int'(e.wrap));
    endtask

    initial begin
        vec_t va[$];
        vec_t vb[$];
        vec_t vc[$];
        exp_t e;

        // defaults: reset, count 0..7,0,1, hold, reset beats load and wrap
        va.push_back(mk(1,0,0,1,0, 0,0, 0,0));
        va.push_back(mk(1,0,0,1,0, 1,0, 0,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 1,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 2,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 3,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 4,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 5,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 6,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 7,0));
        va.push_back(mk(0,1,0,1,0, 1,1, 0,1));
        va.push_back(mk(0,1,0,1,0, 1,0, 1,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 2,0));
        va.push_back(mk(0,0,0,1,0, 1,0, 2,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 3,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 4,0));
        va.push_back(mk(1,1,1,1,6, 1,0, 0,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 1,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 2,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 3,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 4,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 5,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 6,0));
        va.push_back(mk(0,1,0,1,0, 1,0, 7,0));
        va.push_back(mk(1,1,0,1,0, 1,1, 0,0));
        va.push_back(mk(0,1,0,0,0, 1,1, 7,1));
        va.push_back(mk(0,1,0,1,0, 1,1, 0,1));

        // modulus 6: count down, load, clamp, load priority, direction
        vb.push_back(mk(1,0,0,0,0, 0,0, 0,0));
        vb.push_back(mk(0,1,0,0,0, 1,1, 5,1));
        vb.push_back(mk(0,1,0,0,0, 1,0, 4,0));
        vb.push_back(mk(0,1,0,0,0, 1,0, 3,0));
        vb.push_back(mk(0,1,0,0,0, 1,0, 2,0));
        vb.push_back(mk(0,1,0,0,0, 1,0, 1,0));
        vb.push_back(mk(0,1,0,0,0, 1,0, 0,0));
        vb.push_back(mk(0,1,0,0,0, 1,1, 5,1));
        vb.push_back(mk(0,1,0,0,0, 1,0, 4,0));
        vb.push_back(mk(0,0,1,0,3, 1,0, 3,0));
        vb.push_back(mk(0,0,1,0,7, 1,0, 5,0));
        vb.push_back(mk(0,1,1,1,2, 1,0, 2,0));
        vb.push_back(mk(0,0,0,1,0, 1,0, 2,0));
        vb.push_back(mk(0,1,0,1,0, 1,0, 3,0));
        vb.push_back(mk(0,1,0,0,0, 1,0, 2,0));
        vb.push_back(mk(0,0,1,1,5, 1,0, 5,0));
        vb.push_back(mk(0,1,0,1,0, 1,1, 0,1));
        vb.push_back(mk(0,1,1,1,6, 1,0, 5,0));

        // saturating: hold at 7 going up, hold at 0 going down
        vc.push_back(mk(1,0,0,1,0, 0,0, 0,0));
        vc.push_back(mk(0,0,1,1,6, 1,0, 6,0));
        vc.push_back(mk(0,1,0,1,0, 1,0, 7,0));
        vc.push_back(mk(0,1,0,1,0, 1,1, 7,0));
        vc.push_back(mk(0,1,0,1,0, 1,1, 7,0));
        vc.push_back(mk(0,1,0,1,0, 1,1, 7,0));
        vc.push_back(mk(0,0,1,0,1, 1,0, 1,0));
        vc.push_back(mk(0,1,0,0,0, 1,0, 0,0));
        vc.push_back(mk(0,1,0,0,0, 1,1, 0,0));
        vc.push_back(mk(0,1,0,0,0, 1,1, 0,0));

        rst = 4'hF;
        if_a.en = 0; if_a.load = 0; if_a.up = 1; if_a.d = 0;
        if_b.en = 0; if_b.load = 0; if_b.up = 1; if_b.d = 0;
        if_c.en = 0; if_c.load = 0; if_c.up = 1; if_c.d = 0;
        if_l.en = 0; if_l.load = 0; if_l.up = 1; if_l.d = 0;
        if_h.load = 0; if_h.up = 1; if_h.d = 0;
        @(posedge clk);
        #1;

        foreach (va[i]) run(0, va[i], $sformatf("a%0d", i));
        foreach (vb[i]) run(1, vb[i], $sformatf("b%0d", i));
        foreach (vc[i]) run(2, vc[i], $sformatf("c%0d", i));

        // cascade: {high,low} must step 1..63 then back to 0
        if_l.en = 1'b1;
        rst[3] = 1'b1;
        @(posedge clk);
        #1;
        check("casc.rst", int'(get_q(3)), 0);
        rst[3] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            e.id = 3; e.q = 6'((i + 1) % 64); e.wrap = (i % 8 == 7);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("casc%0d.q", i), int'(get_q(e.id)), int'(e.q));
            check($sformatf("casc%0d.wrap", i),
                  int'(get_wrap(e.id)), int'(e.wrap));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_mod_counter.md
Name: sync_mod_counter

Overview:
Parametrised synchronous modulo-N up/down counter. Successor to the 3-bit ripple counter built from T flip-flops. All bits change on the same clock edge, so there is no ripple skew. Adds:
- width and modulus parameters
- up/down direction
- parallel load
- optional saturation
- cascadable terminal-count output and a registered wrap pulse

Used as a timebase and event counter. Instances chain through tc into the next stage's en.

Parameters:
WIDTH, 3, counter width in bits; legal range 1..32.
MODULUS, 8, count range is 0..MODULUS-1; legal range 2..2**WIDTH; a value outside this range is an elaboration error.
SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends of the range.

Ports:
clk  input  1  clock; every state change happens on its rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  count enable; one step per cycle while high.
load  input  1  parallel load strobe.
up  input  1  direction: 1 = increment, 0 = decrement.
d  input  WIDTH  value to load.
q  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational.
wrap  output  1  one-cycle pulse, registered.

Behaviour:
- Clocking: single clock clk. Reset rst is synchronous and active-high. There is no asynchronous path into the state.
- Reset: when rst is sampled high at a rising edge, q<=0 and wrap<=0. rst has priority over every other input. A reset in the middle of a count clears state on that edge, and the next cycle starts from 0.
- Priority per edge (highest first): rst, then load, then en, then hold.
- Load:
  - q <= d when d <= MODULUS-1; otherwise q <= MODULUS-1 (clamped).
  - Load ignores en and up.
  - wrap <= 0 on a load cycle.
- Count (en=1, load=0):
  - up=1: if q < MODULUS-1 then q <= q+1. If q == MODULUS-1, then q <= 0 and wrap <= 1 when SATURATE=0; q holds and wrap <= 0 when SATURATE=1.
  - up=0: if q > 0 then q <= q-1. If q == 0, then q <= MODULUS-1 and wrap <= 1 when SATURATE=0; q holds and wrap <= 0 when SATURATE=1.
- Hold (en=0, load=0): q unchanged; wrap <= 0.
- wrap is high for exactly one cycle following each wrap event. In SATURATE=1 it is never asserted.
- tc = en & ~load & (up ? q==MODULUS-1 : q==0). It is purely combinational from the current q and inputs, with no latency. Chain instances by connecting stage k's tc to stage k+1's en.
- Arithmetic:
  - Comparisons are unsigned, at WIDTH bits.
  - When MODULUS == 2**WIDTH, wrap-around equals natural overflow, but the explicit compare logic is still used.
  - q never leaves the range 0..MODULUS-1 after reset.
- A direction change takes effect on the same edge it is sampled. There is no dead cycle.
- Latency: q reflects a load or step on the edge after the inputs are sampled.

Test Plan:
- Defaults (WIDTH=3, MODULUS=8, SATURATE=0). Apply rst=1 for 2 cycles, then en=1, up=1 for 10 cycles. Required: q = 0,1,…,7,0,1. tc=1 only while q=7. wrap high exactly one cycle, the cycle q=0 after the 7.
- MODULUS=6, en=1, up=0 starting from reset. Required: q = 0,5,4,3,2,1,0,5. wrap pulses after each 0→5 transition. tc=1 while q=0.
- MODULUS=6. Load d=3, then d=7. Required: q=3, then q=5 (clamped). Then assert load=1 and en=1 with d=2 together: q=2 (load wins), tc=0.
- SATURATE=1, MODULUS=8. From q=6, count up for 4 cycles: q = 7,7,7,7, wrap never asserted. Then up=0 from q=1 for 3 cycles: q = 0,0,0.
- Reset mid-count: at q=4 with en=1, assert rst for one cycle together with load=1, d=6. Required: q=0 and wrap=0 on that edge. Counting resumes 1,2,… afterwards.
- Cascade two instances (WIDTH=3, MODULUS=8), low.tc → high.en, with en=1, up=1 for 64 cycles. Required: the concatenated {high.q, low.q} steps 0..63 with no skipped or doubled values, then returns to 0.
